// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
// Results are computed at accept, parked in a pending register, and committed when the busy count expires.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;
  typedef enum logic {IDLE, RUN} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   pend_q, pend_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_mul, is_div, mul_sgn, a_neg, b_neg, b_zero;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod, div_res;
  logic [WIDTH-1:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  always_comb begin
    is_mul  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
    is_div  = (op == OP_DIV) || (op == OP_DIVU);
    mul_sgn = (op == OP_MULT) || ((op == OP_MADD) && sign);
    a_ext   = mul_sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    b_ext   = mul_sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    prod    = a_ext * b_ext;
    a_neg   = (op == OP_DIV) && A[WIDTH-1];
    b_neg   = (op == OP_DIV) && B[WIDTH-1];
    b_zero  = (B == '0);
    a_mag   = a_neg ? -A : A;
    b_mag   = b_neg ? -B : B;
    b_safe  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    // Most-negative / -1 yields quotient = A, remainder = 0 through the magnitude path.
    quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
    div_res = b_zero ? {A, {WIDTH{1'b1}}} : {rem, quo};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE && start) begin
      if (is_mul) begin
        pend_d  = (op == OP_MADD) ? {hi_q, lo_q} + prod : prod;
        cnt_d   = CW'(MULT_CYCLES);
        state_d = RUN;
      end else if (is_div) begin
        pend_d  = div_res;
        cnt_d   = CW'(DIV_CYCLES);
        state_d = RUN;
      end else if (op == OP_MTHI) begin
        hi_d = A;
      end else if (op == OP_MTLO) begin
        lo_d = A;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        {hi_d, lo_d} = pend_q;
        state_d      = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed table, hand-written corner sequences and randomized ops against an arithmetic model.
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        sign;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mhi = '0, mlo = '0;
  typedef struct {
    logic [2:0]  op;
    logic        s;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;
  vec_t tbl[12];
  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
    .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void model(input logic [2:0] o, input logic s, input logic [31:0] x, y,
                                input logic [31:0] h, l, output logic [31:0] nh, nl, output int cyc);
    logic [63:0] p;
    nh = h;
    nl = l;
    cyc = 0;
    if (o == 3'd1 || o == 3'd2 || o == 3'd7) begin
      if (o == 3'd1 || (o == 3'd7 && s)) p = longint'(int'(x)) * longint'(int'(y));
      else p = {32'd0, x} * {32'd0, y};
      if (o == 3'd7) p = p + {h, l};
      {nh, nl} = p;
      cyc = 5;
    end else if (o == 3'd3 || o == 3'd4) begin
      cyc = 10;
      if (y == 0) begin
        nh = x;
        nl = '1;
      end else if (o == 3'd3 && x == 32'h8000_0000 && y == '1) begin
        nh = '0;
        nl = x;
      end else if (o == 3'd3) begin
        nl = int'(x) / int'(y);
        nh = int'(x) % int'(y);
      end else begin
        nl = x / y;
        nh = x % y;
      end
    end else if (o == 3'd5) nh = x;
    else if (o == 3'd6) nl = x;
  endfunction
  // Called just after a falling edge; returns just after the following falling edge.
  task automatic issue(input logic [2:0] o, input logic s, input logic [31:0] x, y);
    start = 1'b1;
    op = o;
    sign = s;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    op = $urandom;
    a = $urandom;
    b = $urandom;
  endtask
  task automatic run_op(input string name, input logic [2:0] o, input logic s, input logic [31:0] x, y,
                        input logic [31:0] eh, el, input int ecyc);
    int  cyc = 0;
    bit  hold = 1'b1;
    issue(o, s, x, y);
    while (busy && cyc < 50) begin
      cyc++;
      if (hi !== mhi || lo !== mlo) hold = 1'b0;
      @(negedge clk);
    end
    check({name, " cycles"}, 64'(cyc), 64'(ecyc));
    check({name, " hold"}, 64'(hold), 64'd1);
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    check({name, " busy"}, 64'(busy), 64'd0);
    mhi = eh;
    mlo = el;
  endtask
  initial begin
    logic [31:0] eh, el;
    int          ec, cyc;
    bit          quiet;
    tbl[0]  = '{3'd1, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    tbl[1]  = '{3'd2, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5};
    tbl[2]  = '{3'd3, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tbl[3]  = '{3'd4, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3, 10};
    tbl[4]  = '{3'd3, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10};
    tbl[5]  = '{3'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10};
    tbl[6]  = '{3'd6, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0};
    tbl[7]  = '{3'd7, 1'b1, 32'd1, 32'd1, 32'd1, 32'd0, 5};
    tbl[8]  = '{3'd5, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0, 0};
    tbl[9]  = '{3'd4, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10};
    tbl[10] = '{3'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd0, 5};
    tbl[11] = '{3'd0, 1'b1, 32'hABCD_0123, 32'd9, 32'd4, 32'd0, 0};
    reset = 1'b0;
    start = 1'b0;
    op = '0;
    sign = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].cyc);
    // Requests landing while busy must be dropped, including MTHI.
    model(3'd1, 1'b0, 32'h0000_1234, 32'hFFFF_0003, mhi, mlo, eh, el, ec);
    issue(3'd1, 1'b0, 32'h0000_1234, 32'hFFFF_0003);
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; op = 3'd5; a = 32'hDEAD; b = '0;
      end else if (cyc == 3) begin
        start = 1'b1; op = 3'd4; a = 32'd9; b = 32'd3;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore cycles", 64'(cyc), 64'd5);
    check("ignore hi", 64'(hi), 64'(eh));
    check("ignore lo", 64'(lo), 64'(el));
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy || hi !== eh || lo !== el) quiet = 1'b0;
    end
    check("ignore no late op", 64'(quiet), 64'd1);
    mhi = eh;
    mlo = el;
    // Reset mid-divide abandons the result.
    issue(3'd3, 1'b0, 32'd100, 32'd7);
    cyc = 1;
    while (busy && cyc < 4) begin
      cyc++;
      @(negedge clk);
    end
    check("rst pre busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("rst async busy", 64'(busy), 64'd0);
    check("rst async hi", 64'(hi), 64'd0);
    check("rst async lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy || hi !== 0 || lo !== 0) quiet = 1'b0;
    end
    check("rst no late commit", 64'(quiet), 64'd1);
    mhi = '0;
    mlo = '0;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic        rs;
      logic [31:0] ra, rb;
      int          sel;
      ro = 3'($urandom_range(0, 7));
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = '1;
      end else if (sel == 2) rb = 32'($urandom_range(1, 5));
      model(ro, rs, ra, rb, mhi, mlo, eh, el, ec);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, rs, ra, rb, eh, el, ec);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit holding the HI/LO register pair. Sits in the EX stage of the pipelined core.
- Executes MULT/MULTU/DIV/DIVU/MADD/MADDU over a configurable number of busy cycles. MTHI/MTLO write in a single cycle.
- Raises busy so the hazard unit stalls any following MDU-class instruction.
- HI/LO are exposed continuously for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request strobe, sampled on the rising edge.
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD. MADDU is selected by op=7 with sign=0.
- sign  in  1  signedness for MADD only (1 signed, 0 unsigned).
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- busy  out  1  operation in flight.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset: while reset==0, HI=0, LO=0, busy=0, counter=0, pending=0, asynchronously. Reset mid-operation abandons the operation and leaves no later HI/LO update.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter = remaining cycles).
- Accept: a request is accepted at an edge with start=1, busy=0 and op in {1,2,3,4,7}.
  - The result is computed from A/B sampled at that edge and stored in a 2*WIDTH pending register.
  - counter <= MULT_CYCLES (ops 1,2,7) or DIV_CYCLES (ops 3,4).
  - busy <= 1, giving IDLE->RUN.
- RUN: each edge decrements counter. At the edge where counter==1:
  - {HI,LO} <= pending, busy <= 0, RUN->IDLE.
  - busy is therefore high for exactly N cycles.
  - New HI/LO values are visible in the cycle busy first reads 0.
- MTHI/MTLO: with start=1, busy=0 and op 5/6, HI<=A or LO<=A at that edge. busy stays 0.
- Ignored requests:
  - start=1 while busy=1: any op, including MTHI/MTLO, is ignored. The hazard unit must not issue one; the bench checks it is dropped.
  - op 0 with start=1: no effect.
  - start=0: op is don't-care.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH product; HI = upper half, LO = lower half.
  - MULTU: the same, unsigned.
  - MADD: pending = {HI,LO} + product, modulo 2^(2*WIDTH). HI/LO are taken at the accept edge. Signed product when sign=1, unsigned when sign=0.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU, B==0): LO = all ones, HI = A. Normal latency applies.
- Signed overflow (DIV, A = most-negative, B = all ones): LO = A, HI = 0.
- Result timing: results are committed only at completion. HI/LO hold their old values throughout RUN.

Test Plan (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10):
- MULT, A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA. HI/LO stay unchanged during busy.
- DIV, A=0xFFFFFFF9, B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=7, B=2 -> LO=3, HI=1.
- DIV, A=5, B=0 -> HI=5, LO=0xFFFFFFFF. DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO A=0xFFFFFFFF, then MADD sign=1, A=1, B=1 -> after 5 cycles HI=1, LO=0. MTHI 0x12345678 -> HI=0x12345678 next cycle with busy=0.
- Start MULT; on cycle 2 of busy assert MTHI A=0xDEAD and DIVU A=9, B=3 -> both ignored. Final HI/LO are the MULT result and busy falls after 5 cycles total.
- Start DIV; pull reset low on cycle 4 -> busy=0, HI=0, LO=0 immediately. After release, no late commit occurs over the next 10 cycles.
